bcd_count_ctrl: RTL and testbench
=================================

Name: bcd_count_ctrl

Overview:
- Sequencing controller for a bank of NDIG cascaded 4-bit BCD digit counters (one digit counter per digit, each with increment-enable and sync-clear inputs).
- Generates a prescaled count tick, per-digit increment enables with decimal carry chaining, and terminal-count detection against a programmable BCD target.
- Provides start/stop/clear command handling through a 4-state FSM.
- Sits between the control logic and the digit counter datapath; digit values are fed back on q_all.

Parameters:
- NDIG, 2, number of BCD digits controlled (1..8).
- PRESCALE, 4, clocks per count tick while running (must be >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin or resume counting (level sampled each clock).
- stop  input  1  pause counting.
- clear  input  1  abort and zero the digits.
- target  input  4*NDIG  BCD terminal value; digit 0 in bits [3:0].
- q_all  input  4*NDIG  current digit values fed back from the datapath.
- dig_inc  output  NDIG  per-digit increment enable, one-clock pulse.
- dig_clr  output  1  synchronous clear to all digits, one-clock pulse.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-clock pulse on terminal count.
- ovf  output  1  one-clock pulse when all digits wrap from 9..9 to 0..0.
- tick  output  1  one-clock pulse per prescaler expiry.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, prescaler=0.
  - dig_inc, dig_clr, done, ovf, tick, busy all 0.
- All outputs are registered and appear one clock after the deciding cycle.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Command priority: clear > stop > start.
- IDLE:
  - start -> RUN, prescaler=0.
  - clear -> dig_clr pulse, stay IDLE.
- RUN:
  - Prescaler increments every clock.
  - When prescaler==PRESCALE-1 (the tick cycle), the prescaler wraps to 0.
  - clear -> IDLE with a dig_clr pulse; prescaler=0.
  - stop -> PAUSE; the prescaler holds its value.
- PAUSE:
  - Prescaler frozen.
  - start -> RUN, resuming from the held prescaler value.
  - clear -> IDLE with a dig_clr pulse.
- DONE:
  - Prescaler held at 0.
  - clear -> IDLE with a dig_clr pulse.
  - start -> dig_clr pulse and RUN with prescaler=0 (restart from zero).
- Tick-cycle evaluation (RUN only, no clear/stop in the same cycle), using q_all as sampled in that cycle:
  - tick pulses next cycle.
  - If q_all==target: no increment; done pulses; state -> DONE.
  - Otherwise: dig_inc[0]=1, and dig_inc[k]=1 iff digits 0..k-1 all equal 9.
  - If every digit equals 9, all dig_inc bits are 1 and ovf pulses (wrap to 0..0); counting continues.
- stop or clear in the tick cycle suppresses that tick entirely: no dig_inc, done, or ovf.
- Digit values greater than 9 in q_all are treated as "not 9" for carry purposes; no correction is applied.
- busy = (state==RUN || state==PAUSE), registered.
- Reset asserted mid-count returns to the reset values immediately. The controller does not clear the digits on reset; the datapath clears its own digits on rst.

Optional Feature:
- Macro: BCD_CTRL_AUTO_RELOAD_EN.
- Defined: on a terminal match in the tick cycle, done and dig_clr pulse together and the FSM stays in RUN (free-running modulo target+1 counter). DONE is unreachable.
- Undefined: terminal match -> DONE as described in Behaviour.

Test Plan (NDIG=2, PRESCALE=4, bench models two BCD digit counters driven by dig_inc/dig_clr):
- Reset: hold rst=0 mid-run -> all outputs 0 and state IDLE while low. After release with start=0 -> no dig_inc activity for 20 clocks.
- Basic count: start pulse at edge E0 with target=8'h99 (unreachable before wrap) -> first dig_inc=2'b01 visible after E4, then one pulse every 4 clocks. After 10 ticks q_all=8'h10, with dig_inc=2'b11 on the 10th.
- Wrap: preload digits to 8'h99, target=8'h50, run -> one tick later dig_inc=2'b11 and ovf=1, q_all becomes 8'h00, counting continues.
- Terminal: target=8'h25 from 00 -> digits stop at 8'h25, done pulses once, busy falls, state DONE. A later start -> dig_clr pulse, then count from 00.
- Pause/resume: stop asserted when prescaler=2 -> no dig_inc during a 10-clock pause. Resuming start -> next dig_inc 2 clocks later (prescaler resumes at 2). Simultaneous stop+start -> PAUSE.
- Clear priority and tick collision:
  - clear+stop+start together in RUN -> IDLE with a single dig_clr pulse.
  - stop asserted on the tick cycle -> no dig_inc for that tick.
  - With BCD_CTRL_AUTO_RELOAD_EN and target=8'h03: q_all sequence 0,1,2,3,0,… with done+dig_clr at each 3.

Source files
------------

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for NDIG cascaded BCD digit counters: prescaled tick, carry-chained increments, terminal detect.
// Optional build macro BCD_CTRL_AUTO_RELOAD_EN: terminal match reloads (dig_clr) and keeps running instead of entering DONE.
module bcd_count_ctrl #(
    parameter int NDIG     = 2,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic [4*NDIG-1:0] target,
    input  logic [4*NDIG-1:0] q_all,
    output logic [NDIG-1:0]   dig_inc,
    output logic              dig_clr,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              tick,
    output logic [1:0]        dbg_state
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [NDIG-1:0] dig_inc_q, dig_inc_d;
    logic            dig_clr_q, dig_clr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            tick_q, tick_d;

    logic [NDIG-1:0] nine;
    logic [NDIG-1:0] carry;
    logic            all_nine;
    logic            at_target;
    logic            tick_cycle;

    // Digits above 9 are simply "not 9"; the chain never corrects them.
    always_comb begin
        nine  = '0;
        carry = '0;
        for (int k = 0; k < NDIG; k++) begin
            nine[k] = (q_all[4*k +: 4] == 4'd9);
        end
        carry[0] = 1'b1;
        for (int k = 1; k < NDIG; k++) begin
            carry[k] = carry[k-1] & nine[k-1];
        end
    end

    assign all_nine   = &nine;
    assign at_target  = (q_all == target);
    assign tick_cycle = (presc_q == PRESC_LAST);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        dig_inc_d = '0;
        dig_clr_d = 1'b0;
        done_d    = 1'b0;
        ovf_d     = 1'b0;
        tick_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (clear) begin
                    dig_clr_d = 1'b1;
                end else if (!stop && start) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (clear) begin
                    state_d   = ST_IDLE;
                    dig_clr_d = 1'b1;
                    presc_d   = '0;
                end else if (stop) begin
                    state_d = ST_PAUSE;
                end else if (tick_cycle) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (at_target) begin
                        done_d = 1'b1;
`ifdef BCD_CTRL_AUTO_RELOAD_EN
                        dig_clr_d = 1'b1;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        dig_inc_d = carry;
                        ovf_d     = all_nine;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            ST_PAUSE: begin
                if (clear) begin
                    state_d   = ST_IDLE;
                    dig_clr_d = 1'b1;
                    presc_d   = '0;
                end else if (!stop && start) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                presc_d = '0;
                if (clear) begin
                    state_d   = ST_IDLE;
                    dig_clr_d = 1'b1;
                end else if (!stop && start) begin
                    state_d   = ST_RUN;
                    dig_clr_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            dig_inc_q <= '0;
            dig_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            dig_inc_q <= dig_inc_d;
            dig_clr_q <= dig_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            tick_q    <= tick_d;
        end
    end

    assign dig_inc   = dig_inc_q;
    assign dig_clr   = dig_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign tick      = tick_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl (NDIG=2, PRESCALE=4) with a two-digit BCD counter model on q_all.
module tb_bcd_count_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clear;
  logic [7:0] target;
  logic [7:0] q_all;
  logic [1:0] dig_inc;
  logic       dig_clr;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       tick;
  logic [1:0] dbg_state;

  logic       preload_en;
  logic [7:0] preload_val;

  int checks = 0;
  int errors = 0;
  int cnt;

  bcd_count_ctrl #(.NDIG(2), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .target(target), .q_all(q_all), .dig_inc(dig_inc), .dig_clr(dig_clr),
    .busy(busy), .done(done), .ovf(ovf), .tick(tick), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // digit counter datapath model
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_all <= 8'h00;
    end else if (preload_en) begin
      q_all <= preload_val;
    end else if (dig_clr) begin
      q_all <= 8'h00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (dig_inc[k]) q_all[4*k +: 4] <= (q_all[4*k +: 4] == 4'd9) ? 4'd0 : q_all[4*k +: 4] + 4'd1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_inc"}, 32'(dig_inc), 32'd0);
    chk({tag, "_clr"}, 32'(dig_clr), 32'd0);
    chk({tag, "_outs"}, {28'd0, busy, done, ovf, tick}, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    target = 8'h99; preload_en = 1'b0; preload_val = 8'h00;

    // reset state, then idle with start low for 20 clocks
    step(2);
    chk_idle_outputs("reset");
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (dig_inc != 2'b00 || tick || busy) cnt++;
    end
    chk("idle_quiet", 32'(cnt), 32'd0);

    // basic count: start sampled at E0, first increment visible after E4
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("run_state", 32'(dbg_state), 32'(S_RUN));
    chk("run_busy", 32'(busy), 32'd1);
    step(3);
    chk("pre_tick_inc", 32'(dig_inc), 32'd0);
    step(1);
    chk("tick1_inc", 32'(dig_inc), 32'h1);
    chk("tick1_tick", 32'(tick), 32'd1);
    for (int i = 2; i <= 10; i++) begin
      step(4);
      if (i == 9) chk("tick9_inc", 32'(dig_inc), 32'h1);
    end
    chk("tick10_carry", 32'(dig_inc), 32'h3);
    step(1);
    chk("count_10", 32'(q_all), 32'h10);

    // pause with prescaler at 2, then resume: increment 2 clocks later
    step(1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("pause_state", 32'(dbg_state), 32'(S_PAUSE));
    chk("pause_busy", 32'(busy), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (dig_inc != 2'b00) cnt++;
    end
    chk("pause_quiet", 32'(cnt), 32'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("resume_state", 32'(dbg_state), 32'(S_RUN));
    step(1);
    chk("resume_early", 32'(dig_inc), 32'd0);
    step(1);
    chk("resume_inc", 32'(dig_inc), 32'h1);

    // stop+start together -> PAUSE
    stop = 1'b1; start = 1'b1;
    step(1);
    stop = 1'b0; start = 1'b0;
    chk("stop_start_pause", 32'(dbg_state), 32'(S_PAUSE));
    chk("count_11", 32'(q_all), 32'h11);

    // clear+stop+start together in RUN -> IDLE, single dig_clr
    start = 1'b1;
    step(1);
    clear = 1'b1; stop = 1'b1;
    step(1);
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    chk("clr_all_state", 32'(dbg_state), 32'(S_IDLE));
    chk("clr_all_pulse", 32'(dig_clr), 32'd1);
    chk("clr_all_busy", 32'(busy), 32'd0);
    step(1);
    chk("clr_single", 32'(dig_clr), 32'd0);
    chk("clr_digits", 32'(q_all), 32'h00);

    // stop on the tick cycle suppresses the tick
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_tick_inc", 32'(dig_inc), 32'd0);
    chk("stop_tick_tick", 32'(tick), 32'd0);
    chk("stop_tick_state", 32'(dbg_state), 32'(S_PAUSE));
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("pause_clear", {30'd0, dig_clr, dbg_state == S_IDLE}, 32'h3);

    // wrap from 99 with an unreachable target
    target = 8'h50;
    preload_en = 1'b1; preload_val = 8'h99;
    step(1);
    preload_en = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    chk("wrap_pre", {30'd0, dig_inc}, 32'd0);
    step(1);
    chk("wrap_inc", 32'(dig_inc), 32'h3);
    chk("wrap_ovf", 32'(ovf), 32'd1);
    step(1);
    chk("wrap_q", 32'(q_all), 32'h00);
    chk("wrap_ovf_once", 32'(ovf), 32'd0);
    step(3);
    chk("wrap_continue", 32'(dig_inc), 32'h1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
    chk("wrap_cleared", 32'(q_all), 32'h00);

    // terminal count at 25
    target = 8'h25;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(103);
    chk("term_q", 32'(q_all), 32'h25);
    chk("term_pre_done", 32'(done), 32'd0);
    step(1);
    chk("term_done", 32'(done), 32'd1);
    chk("term_no_inc", 32'(dig_inc), 32'd0);
`ifdef BCD_CTRL_AUTO_RELOAD_EN
    chk("reload_clr", 32'(dig_clr), 32'd1);
    chk("reload_state", 32'(dbg_state), 32'(S_RUN));
    step(1);
    chk("reload_q", 32'(q_all), 32'h00);
    chk("reload_done_once", 32'(done), 32'd0);
    step(3);
    chk("reload_inc", 32'(dig_inc), 32'h1);
`else
    chk("term_state", 32'(dbg_state), 32'(S_DONE));
    chk("term_busy", 32'(busy), 32'd0);
    step(5);
    chk("term_hold_q", 32'(q_all), 32'h25);
    chk("term_done_once", 32'(done), 32'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("restart_clr", 32'(dig_clr), 32'd1);
    chk("restart_state", 32'(dbg_state), 32'(S_RUN));
    step(1);
    chk("restart_q", 32'(q_all), 32'h00);
    step(3);
    chk("restart_inc", 32'(dig_inc), 32'h1);
`endif

    // asynchronous reset mid-count
    step(2);
    rst = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    step(3);
    chk_idle_outputs("rst_hold");
    rst = 1'b1;
    step(5);
    chk("post_rst_quiet", {30'd0, dig_inc}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
